// File: rtl/sender_mpi.sv
// Credit-based flit transmitter: buffers local flits in a small FIFO and forwards
// them on the valid/data link while downstream credits remain; yummy pulses return credits.
module sender_mpi #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned CREDITS    = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              yummy_i,
   output logic [3:0]        credits_o,
   output logic [31:0]       sent_cnt_o,
   output logic              ovf_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [3:0]      CredMax = 4'(CREDITS);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [3:0]        credits_q, credits_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [31:0]       sent_cnt_q, sent_cnt_d;
   logic              ovf_q, ovf_d;

   logic full;
   logic push;
   logic send;

   // Send decision uses registered state only, so a flit pushed into an empty
   // FIFO cannot leave on the same edge and a yummy only helps on the next edge.
   always_comb begin
      full = (count_q == CntFull);
      push = in_valid_i & ~full;
      send = (count_q != '0) & (credits_q != '0);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (send) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, send})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      credits_d = credits_q;
      ovf_d     = ovf_q;
      if (send && !yummy_i) begin
         credits_d = credits_q - 4'd1;
      end else if (!send && yummy_i) begin
         if (credits_q == CredMax) begin
            ovf_d = 1'b1;
         end else begin
            credits_d = credits_q + 4'd1;
         end
      end
   end

   always_comb begin
      valid_d    = send;
      data_d     = data_q;
      sent_cnt_d = sent_cnt_q;
      if (send) begin
         data_d     = mem_q[rd_ptr_q];
         sent_cnt_d = sent_cnt_q + 32'd1;
      end
   end

   // Payload storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         credits_q  <= CredMax;
         valid_q    <= 1'b0;
         data_q     <= '0;
         sent_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         credits_q  <= credits_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         sent_cnt_q <= sent_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign in_ready_o = ~full;
   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign credits_o  = credits_q;
   assign sent_cnt_o = sent_cnt_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_sender_mpi.sv
// Self-checking bench for sender_mpi: directed test-plan scenarios followed by random
// traffic, compared against a queue-based model of the link transmitter.
module tb_sender_mpi;

   localparam int unsigned DataW   = 64;
   localparam int unsigned Credits = 3;
   localparam int unsigned Depth   = 4;

   logic             clk_i = 1'b0;
   logic             rstn_i = 1'b0;
   logic             in_valid_i = 1'b0;
   logic [DataW-1:0] in_data_i = '0;
   logic             in_ready_o;
   logic             valid_o;
   logic [DataW-1:0] data_o;
   logic             yummy_i = 1'b0;
   logic [3:0]       credits_o;
   logic [31:0]      sent_cnt_o;
   logic             ovf_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   logic [DataW-1:0] mq [$];
   int               m_cred;
   logic             m_valid;
   logic [DataW-1:0] m_data;
   logic [31:0]      m_sent;
   logic             m_ovf;

   sender_mpi #(
      .DATA_W    (DataW),
      .CREDITS   (Credits),
      .FIFO_DEPTH(Depth)
   ) u_dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .in_valid_i(in_valid_i),
      .in_data_i (in_data_i),
      .in_ready_o(in_ready_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .yummy_i   (yummy_i),
      .credits_o (credits_o),
      .sent_cnt_o(sent_cnt_o),
      .ovf_o     (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cred  = Credits;
      m_valid = 1'b0;
      m_data  = '0;
      m_sent  = '0;
      m_ovf   = 1'b0;
   endtask

   task automatic check_all();
      check("valid_o", 64'(valid_o), 64'(m_valid));
      check("data_o", data_o, m_data);
      check("credits_o", 64'(credits_o), 64'(m_cred));
      check("sent_cnt_o", 64'(sent_cnt_o), 64'(m_sent));
      check("ovf_o", 64'(ovf_o), 64'(m_ovf));
      check("in_ready_o", 64'(in_ready_o), 64'(mq.size() < Depth));
   endtask

   // One clock: drive inputs, advance model on the edge, compare just after it.
   task automatic step(input logic v, input logic [DataW-1:0] d, input logic y);
      bit snd;
      bit psh;
      in_valid_i = v;
      in_data_i  = d;
      yummy_i    = y;
      @(posedge clk_i);
      snd = (mq.size() > 0) && (m_cred > 0);
      psh = v && (mq.size() < Depth);
      m_valid = snd;
      if (snd) begin
         m_data = mq.pop_front();
         m_sent = m_sent + 32'd1;
      end
      if (psh) mq.push_back(d);
      if (snd && !y) m_cred--;
      else if (!snd && y) begin
         if (m_cred == Credits) m_ovf = 1'b1;
         else m_cred++;
      end
      #1;
      check_all();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
   task automatic async_reset();
      #3;
      rstn_i     = 1'b0;
      in_valid_i = 1'b0;
      yummy_i    = 1'b0;
      #1;
      model_reset();
      check("rst valid_o", 64'(valid_o), 64'd0);
      check("rst credits_o", 64'(credits_o), 64'(Credits));
      check("rst in_ready_o", 64'(in_ready_o), 64'd1);
      check("rst sent_cnt_o", 64'(sent_cnt_o), 64'd0);
      check("rst ovf_o", 64'(ovf_o), 64'd0);
      #2;
      rstn_i = 1'b1;
   endtask

   initial begin
      logic [DataW-1:0] rnd;
      model_reset();
      #12;
      rstn_i = 1'b1;

      // Reset and idle
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

      // Credit exhaustion: three sent, two left buffered
      step(1'b1, 64'h11, 1'b0);
      step(1'b1, 64'h22, 1'b0);
      check("first send valid", 64'(valid_o), 64'd1);
      check("first send data", data_o, 64'h11);
      step(1'b1, 64'h33, 1'b0);
      step(1'b1, 64'h44, 1'b0);
      check("third send data", data_o, 64'h33);
      check("credits exhausted", 64'(credits_o), 64'd0);
      step(1'b1, 64'h55, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);

      // Replenish: each yummy lets one flit out on the following edge
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("replenish 44", data_o, 64'h44);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("replenish 55", data_o, 64'h55);
      check("sent five", 64'(sent_cnt_o), 64'd5);
      step(1'b0, '0, 1'b0);

      // Backpressure with zero credits, then one yummy
      for (int i = 0; i < 4; i++) step(1'b1, 64'hA0 + 64'(i), 1'b0);
      check("full not ready", 64'(in_ready_o), 64'd0);
      step(1'b1, 64'hA4, 1'b0);
      step(1'b1, 64'hA4, 1'b1);
      step(1'b1, 64'hA4, 1'b0);
      check("bp send A0", data_o, 64'hA0);
      check("bp ready again", 64'(in_ready_o), 64'd1);

      // Mid-burst reset: valid_o high with three flits buffered
      check("burst valid before rst", 64'(valid_o), 64'd1);
      async_reset();
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);

      // Overflow when idle at full credit, then send+yummy in the same cycle
      step(1'b0, '0, 1'b1);
      check("ovf set", 64'(ovf_o), 64'd1);
      step(1'b1, 64'hBEEF, 1'b0);
      step(1'b0, '0, 1'b1);
      check("send+yummy credits", 64'(credits_o), 64'(Credits));
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
      check("ovf sticky", 64'(ovf_o), 64'd1);
      async_reset();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rnd = {$urandom, $urandom};
         step(1'($urandom_range(0, 2) != 0), rnd,
              1'((m_cred < Credits || $urandom_range(0, 15) == 0) && $urandom_range(0, 2) == 0));
         if ($urandom_range(0, 120) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sender_mpi.md
# sender_mpi

Credit-based flit transmitter for the MPI-bridged node link, and the transmit-side counterpart of the link receiver. It accepts 64-bit flits from local logic over a valid/ready interface and buffers them in a small FIFO. Flits are forwarded on the valid/data link only while downstream credits remain, and credits are replenished by yummy pulses returned from the far-end receiver. In a fake node, the valid_o/data_o/yummy_i ports connect to the DPI send-data and receive-yummy calls.

## Interface
- DATA_W, 64: flit width.
- CREDITS, 3: initial and maximum downstream credit count (1..15).
- FIFO_DEPTH, 4: local buffer depth in flits (power of two, ≥2).

- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  local flit offered.
- in_data_i  in  DATA_W  local flit payload.
- in_ready_o  out  1  FIFO can accept; combinational, equals !full.
- valid_o  out  1  link flit valid, registered, one-cycle pulse per flit.
- data_o  out  DATA_W  link flit payload, registered.
- yummy_i  in  1  one credit returned per high cycle.
- credits_o  out  4  current credit count.
- sent_cnt_o  out  32  total flits sent, wraps modulo 2^32.
- ovf_o  out  1  sticky error: a yummy arrived while credits were already at CREDITS.

## Operation
- Push: when in_valid_i && in_ready_o at a rising edge, in_data_i is written at the FIFO tail. There is no write-through when full: in_ready_o=0 while count==FIFO_DEPTH, even if a pop occurs in the same cycle.
- Send condition, evaluated on registered state: fifo_count>0 && credits>0.
  - When the condition holds, at the edge: valid_o<=1, data_o<=FIFO head, pop head, sent_cnt+1.
  - Otherwise valid_o<=0 and data_o holds its last value.
- At most one flit is sent per cycle. Flits leave in strict FIFO order.
- Credit update per edge: credits_next = credits - send + yummy_i.
  - Simultaneous send and yummy: credits unchanged.
  - yummy_i when credits==CREDITS and no send in that cycle: credits stay at CREDITS and ovf_o<=1.
  - ovf_o is cleared only by reset.
- Credits never go negative. A send requires credits≥1 before the edge.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged. When count==0, a pushed flit is not sendable in the same edge (no bypass).
- Reset, asynchronous, at any time including mid-burst: the FIFO empties, all buffered flits are dropped, and credits return to CREDITS.

## Timing
- Reset values: valid_o=0, data_o=0, credits_o=CREDITS, sent_cnt_o=0, ovf_o=0, in_ready_o=1.
- Latency: a flit pushed at edge k with an empty FIFO and credits>0 drives valid_o=1 after edge k+1. The minimum push-to-link latency is one cycle.
- Back-to-back throughput is 1 flit/cycle while the FIFO is non-empty and credits>0.
- With no yummies returned, exactly CREDITS flits are sent, then valid_o stays 0.
- A yummy sampled at edge k allows a send at edge k+1 at the earliest: the credit register updates at k and the send decision at k+1 uses it.
- credits_o, sent_cnt_o and ovf_o are registered and reflect the state after the last edge.

## Test plan
- Reset and idle:
  - Stimulus: hold in_valid_i=0 and yummy_i=0 for 10 cycles after releasing rstn_i.
  - Required: valid_o=0, credits_o=3, in_ready_o=1, sent_cnt_o=0 throughout.
- Credit exhaustion:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles with no yummy.
  - Required: valid_o pulses on 3 consecutive cycles carrying 0x11, 0x22, 0x33, then credits_o=0, the FIFO holds 2 flits, and valid_o stays 0.
- Replenish:
  - Stimulus: continuing from credit exhaustion, pulse yummy_i for 2 single cycles.
  - Required: 0x44 and then 0x55 are sent, each one cycle after its yummy; final credits_o=0 and sent_cnt_o=5.
- Backpressure:
  - Stimulus: with credits at 0, push 4 flits; then hold in_valid_i=1 with a 5th flit.
  - Required: in_ready_o=0 after the 4th push and the 5th flit is not accepted. After 1 yummy, one flit is sent and in_ready_o returns to 1 the next cycle.
- Simultaneous events and overflow:
  - Stimulus A: a send and yummy_i in the same cycle.
  - Required A: credits_o unchanged.
  - Stimulus B: yummy_i while credits_o=3 and idle.
  - Required B: credits_o stays 3 and ovf_o=1, sticky until reset.
- Mid-burst reset:
  - Stimulus: assert rstn_i low asynchronously while 3 flits are buffered and valid_o=1.
  - Required: valid_o=0 immediately, the FIFO is empty, and credits_o=3.
  - Required after release: no stale flit is sent.
